// File: rtl/sm3_cmprss_ctrl_pkg.sv
// Shared SM3 compression constants, working-register struct, FSM encoding and rotate helpers.
// Optional wipe of working/chaining state is enabled by defining SM3_CMPRSS_ZEROIZE_EN.
package sm3_cmprss_ctrl_pkg;

   localparam logic [31:0] SM3_IV_A = 32'h7380166f;
   localparam logic [31:0] SM3_IV_B = 32'h4914b2b9;
   localparam logic [31:0] SM3_IV_C = 32'h172442d7;
   localparam logic [31:0] SM3_IV_D = 32'hda8a0600;
   localparam logic [31:0] SM3_IV_E = 32'ha96f30bc;
   localparam logic [31:0] SM3_IV_F = 32'h163138aa;
   localparam logic [31:0] SM3_IV_G = 32'he38dee4d;
   localparam logic [31:0] SM3_IV_H = 32'hb0fb0e4e;

   localparam logic [31:0] SM3_T_LO = 32'h79cc4519;
   localparam logic [31:0] SM3_T_HI = 32'h7a879d8a;

   // Field order puts A in the top word so the struct maps directly onto hash_o.
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } sm3_regs_t;

   localparam sm3_regs_t SM3_IV = '{a: SM3_IV_A, b: SM3_IV_B, c: SM3_IV_C, d: SM3_IV_D,
                                    e: SM3_IV_E, f: SM3_IV_F, g: SM3_IV_G, h: SM3_IV_H};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } ctrl_state_t;

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] sm3_p0(input logic [31:0] x);
      return x ^ rotl32(x, 9) ^ rotl32(x, 17);
   endfunction

endpackage

// File: rtl/sm3_cmprss_ceil_comb.sv
// One combinational SM3 compression round; Tj arrives already rotated by (j mod 32).
module sm3_cmprss_ceil_comb
   import sm3_cmprss_ctrl_pkg::*;
(
   input  logic        cmprss_round_sm_16_i,
   input  logic [31:0] tj_i,
   input  logic [31:0] wj_i,
   input  logic [31:0] wjj_i,
   input  sm3_regs_t   st_i,
   output sm3_regs_t   st_o
);

   logic [31:0] a12;
   logic [31:0] ss1;
   logic [31:0] ss2;
   logic [31:0] ff;
   logic [31:0] gg;
   logic [31:0] tt1;
   logic [31:0] tt2;

   assign a12 = rotl32(st_i.a, 12);
   assign ss1 = rotl32(a12 + st_i.e + tj_i, 7);
   assign ss2 = ss1 ^ a12;

   // Rounds 0..15 use parity; later rounds use majority / choose.
   assign ff = cmprss_round_sm_16_i ? (st_i.a ^ st_i.b ^ st_i.c)
                                    : ((st_i.a & st_i.b) | (st_i.a & st_i.c) | (st_i.b & st_i.c));
   assign gg = cmprss_round_sm_16_i ? (st_i.e ^ st_i.f ^ st_i.g)
                                    : ((st_i.e & st_i.f) | (~st_i.e & st_i.g));

   assign tt1 = ff + st_i.d + ss2 + wjj_i;
   assign tt2 = gg + st_i.h + ss1 + wj_i;

   assign st_o.a = tt1;
   assign st_o.b = st_i.a;
   assign st_o.c = rotl32(st_i.b, 9);
   assign st_o.d = st_i.c;
   assign st_o.e = sm3_p0(tt2);
   assign st_o.f = st_i.e;
   assign st_o.g = rotl32(st_i.f, 19);
   assign st_o.h = st_i.g;

endmodule

// File: rtl/sm3_tj_gen.sv
// Round-indexed pre-rotated Tj: a register loaded with T_LO at job start, rotated left by
// one per consumed round, and reloaded with T_HI<<<16 on the step into round 16.
module sm3_tj_gen
   import sm3_cmprss_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        adv_i,
   input  logic        last_lo_i,
   output logic [31:0] tj_o
);

   localparam logic [31:0] T_HI_J16 = rotl32(SM3_T_HI, 16);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tj_o <= SM3_T_LO;
      end else if (load_i) begin
         tj_o <= SM3_T_LO;
      end else if (adv_i) begin
         tj_o <= last_lo_i ? T_HI_J16 : rotl32(tj_o, 1);
      end
   end

endmodule

// File: rtl/sm3_cmprss_ctrl.sv
// Iterative SM3 compression controller: 64 rounds at one per accepted Wj pair, then V ^= A..H.
// Define SM3_CMPRSS_ZEROIZE_EN to wipe A..H after each block, wipe all state on soft clear, and gate hash_o.
module sm3_cmprss_ctrl
   import sm3_cmprss_ctrl_pkg::*;
#(
   parameter int unsigned ROUNDS = 64
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_start_i,
   input  logic         blk_first_i,
   input  logic         soft_clr_i,
   input  logic         wj_valid_i,
   input  logic [31:0]  wj_i,
   input  logic [31:0]  wjj_i,
   output logic         wj_ready_o,
   output logic         busy_o,
   output logic [5:0]   round_o,
   output logic         hash_valid_o,
   input  logic         hash_ready_i,
   output logic [255:0] hash_o
);

   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

   ctrl_state_t state;
   sm3_regs_t   st;
   sm3_regs_t   st_nxt;
   sm3_regs_t   v_reg;
   logic [5:0]  round;
   logic [31:0] tj_cur;
   logic        rnd_sm_16;
   logic        hs;
   logic        start_go;

   assign hs        = wj_ready_o & wj_valid_i;
   assign start_go  = (state == ST_IDLE) & blk_start_i & ~soft_clr_i;
   assign rnd_sm_16 = (round < 6'd16);
   assign round_o   = round;

   sm3_tj_gen u_tj_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (start_go),
      .adv_i     (hs & ~soft_clr_i),
      .last_lo_i (round == 6'd15),
      .tj_o      (tj_cur)
   );

   sm3_cmprss_ceil_comb u_ceil (
      .cmprss_round_sm_16_i (rnd_sm_16),
      .tj_i                 (tj_cur),
      .wj_i                 (wj_i),
      .wjj_i                (wjj_i),
      .st_i                 (st),
      .st_o                 (st_nxt)
   );

   // NOTE: every register in this block is updated with <= so all branches see the
   // pre-edge values of st, v_reg and round, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         st           <= '0;
         v_reg        <= '0;
         round        <= '0;
         busy_o       <= 1'b0;
         wj_ready_o   <= 1'b0;
         hash_valid_o <= 1'b0;
      end else if (soft_clr_i) begin
         state        <= ST_IDLE;
         round        <= '0;
         busy_o       <= 1'b0;
         wj_ready_o   <= 1'b0;
         hash_valid_o <= 1'b0;
`ifdef SM3_CMPRSS_ZEROIZE_EN
         st           <= '0;
         v_reg        <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (blk_start_i) begin
                  st         <= blk_first_i ? SM3_IV : v_reg;
                  v_reg      <= blk_first_i ? SM3_IV : v_reg;
                  round      <= '0;
                  state      <= ST_RUN;
                  busy_o     <= 1'b1;
                  wj_ready_o <= 1'b1;
               end
            end
            ST_RUN: begin
               if (hs) begin
                  st <= st_nxt;
                  if (round == LAST_ROUND) begin
                     round      <= '0;
                     state      <= ST_FINAL;
                     wj_ready_o <= 1'b0;
                  end else begin
                     round <= round + 6'd1;
                  end
               end
            end
            ST_FINAL: begin
               v_reg        <= sm3_regs_t'(st ^ v_reg);
`ifdef SM3_CMPRSS_ZEROIZE_EN
               st           <= '0;
`endif
               state        <= ST_DONE;
               hash_valid_o <= 1'b1;
            end
            ST_DONE: begin
               // A start seen together with hash_ready_i is dropped; it must be reissued in IDLE.
               if (hash_ready_i) begin
                  state        <= ST_IDLE;
                  hash_valid_o <= 1'b0;
                  busy_o       <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SM3_CMPRSS_ZEROIZE_EN
   assign hash_o = hash_valid_o ? v_reg : '0;
`else
   assign hash_o = v_reg;
`endif

endmodule

// File: tb/tb_sm3_cmprss_ctrl.sv
// Directed bench for sm3_cmprss_ctrl: feeds message-expanded Wj/W'j from a local model and
// compares digests, Tj values, latency and handshakes against known SM3 results.
module tb_sm3_cmprss_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         blk_start;
   logic         blk_first;
   logic         soft_clr;
   logic         wj_valid;
   logic [31:0]  wj;
   logic [31:0]  wjj;
   logic         wj_ready;
   logic         busy;
   logic [5:0]   round_o;
   logic         hash_valid;
   logic         hash_ready;
   logic [255:0] hash_o;

   localparam logic [255:0] ABC_DIGEST  =
      256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
   localparam logic [255:0] ABCD_DIGEST =
      256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
   localparam logic [255:0] IV_WORDS    =
      256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

   int n_cmp = 0;
   int n_err = 0;
   int edges = 0;
   int t0;
   int stalls;

   logic [31:0] msg [0:15];
   logic [31:0] w   [0:67];
   logic [31:0] wp  [0:63];

   sm3_cmprss_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .blk_start_i  (blk_start),
      .blk_first_i  (blk_first),
      .soft_clr_i   (soft_clr),
      .wj_valid_i   (wj_valid),
      .wj_i         (wj),
      .wjj_i        (wjj),
      .wj_ready_o   (wj_ready),
      .busy_o       (busy),
      .round_o      (round_o),
      .hash_valid_o (hash_valid),
      .hash_ready_i (hash_ready),
      .hash_o       (hash_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] p1(input logic [31:0] x);
      return x ^ rl(x, 15) ^ rl(x, 23);
   endfunction

   task automatic expand();
      for (int j = 0; j < 16; j++) w[j] = msg[j];
      for (int j = 16; j < 68; j++)
         w[j] = p1(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
      for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
   endtask

   task automatic set_abc();
      for (int j = 0; j < 16; j++) msg[j] = 32'h0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      expand();
   endtask

   task automatic set_abcd(input int blk);
      for (int j = 0; j < 16; j++) msg[j] = (blk == 0) ? 32'h61626364 : 32'h0;
      if (blk != 0) begin
         msg[0]  = 32'h80000000;
         msg[15] = 32'h00000200;
      end
      expand();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic start_blk(input logic first);
      blk_start = 1'b1;
      blk_first = first;
      tick();
      blk_start = 1'b0;
      blk_first = 1'b0;
   endtask

   task automatic feed(input int n_rounds, input bit gaps, input bit probe, output int n_stall);
      int  k = 0;
      int  budget = 0;
      bit  v;
      n_stall = 0;
      while (k < n_rounds && budget < 2000) begin
         v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (gaps) check("round_o tracks handshakes", round_o, k);
         if (probe) begin
            case (k)
               0:  check("tj j=0", dut.tj_cur, 32'h79cc4519);
               1:  check("tj j=1", dut.tj_cur, 32'hf3988a32);
               15: check("sm16 j=15", dut.rnd_sm_16, 1'b1);
               16: begin
                  check("tj j=16", dut.tj_cur, 32'h9d8a7a87);
                  check("sm16 j=16", dut.rnd_sm_16, 1'b0);
               end
               33: check("tj j=33", dut.tj_cur, 32'hf50f3b14);
               default: ;
            endcase
         end
         wj_valid = v;
         wj       = v ? w[k]  : 32'hdeadbeef;
         wjj      = v ? wp[k] : 32'hcafef00d;
         tick();
         if (v) k++;
         else n_stall++;
         budget++;
      end
      wj_valid = 1'b0;
      check("rounds fed within budget", k, n_rounds);
   endtask

   task automatic wait_hash();
      int b = 0;
      while (!hash_valid && b < 300) begin
         tick();
         b++;
      end
      check("hash_valid reached", hash_valid, 1'b1);
   endtask

   task automatic accept();
      hash_ready = 1'b1;
      tick();
      hash_ready = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      blk_start  = 1'b0;
      blk_first  = 1'b0;
      soft_clr   = 1'b0;
      wj_valid   = 1'b0;
      wj         = '0;
      wjj        = '0;
      hash_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy, 1'b0);
      check("reset hash_valid", hash_valid, 1'b0);
      check("reset hash_o", hash_o, '0);
      check("reset round", round_o, 6'd0);
      check("reset wj_ready", wj_ready, 1'b0);
      rst_n = 1'b1;
      tick();

      // Asynchronous reset in the middle of round 20
      set_abc();
      start_blk(1'b1);
      check("run wj_ready", wj_ready, 1'b1);
      check("run busy", busy, 1'b1);
      feed(20, 1'b0, 1'b0, stalls);
      check("round before reset", round_o, 6'd20);
      rst_n = 1'b0;
      #1;
      check("async rst busy", busy, 1'b0);
      check("async rst hash_valid", hash_valid, 1'b0);
      check("async rst hash_o", hash_o, '0);
      check("async rst round", round_o, 6'd0);
      #2;
      rst_n = 1'b1;
      tick();

      // "abc", continuous valid, Tj probes and latency
      start_blk(1'b1);
      t0 = edges;
      feed(64, 1'b0, 1'b1, stalls);
      check("FINAL cycle not yet valid", hash_valid, 1'b0);
      wait_hash();
      check("abc latency edges", edges - t0, 65);
      check("abc digest", hash_o, ABC_DIGEST);
      check("done wj_ready", wj_ready, 1'b0);
      check("done busy", busy, 1'b1);
      tick();
      check("abc digest held", hash_o, ABC_DIGEST);
      hash_ready = 1'b1;
      blk_start  = 1'b1;
      blk_first  = 1'b1;
      tick();
      hash_ready = 1'b0;
      blk_start  = 1'b0;
      blk_first  = 1'b0;
      check("after accept hash_valid", hash_valid, 1'b0);
      check("after accept busy", busy, 1'b0);
      tick();
      check("start in DONE ignored", busy, 1'b0);
`ifdef SM3_CMPRSS_ZEROIZE_EN
      check("hash_o gated when idle", hash_o, '0);
`else
      check("V retained after accept", hash_o, ABC_DIGEST);
`endif

      // "abc" with random wj_valid gaps
      start_blk(1'b1);
      t0 = edges;
      feed(64, 1'b1, 1'b0, stalls);
      wait_hash();
      check("gap latency edges", edges - t0, 65 + stalls);
      check("gap abc digest", hash_o, ABC_DIGEST);
      accept();

      // Two-block 64 x "abcd", chained through V
      set_abcd(0);
      start_blk(1'b1);
      feed(64, 1'b0, 1'b0, stalls);
      wait_hash();
      accept();
      set_abcd(1);
      start_blk(1'b0);
      feed(64, 1'b0, 1'b0, stalls);
      wait_hash();
      for (int i = 0; i < 10; i++) begin
         check("abcd digest stable", hash_o, ABCD_DIGEST);
         check("abcd valid held", hash_valid, 1'b1);
         tick();
      end
      accept();

      // Soft clear at round 40, then a fresh "abc" block
      set_abc();
      start_blk(1'b1);
      feed(40, 1'b0, 1'b0, stalls);
      check("round before soft clear", round_o, 6'd40);
      soft_clr = 1'b1;
      tick();
      soft_clr = 1'b0;
      check("soft clr busy", busy, 1'b0);
      check("soft clr round", round_o, 6'd0);
      check("soft clr wj_ready", wj_ready, 1'b0);
      check("soft clr hash_valid", hash_valid, 1'b0);
`ifdef SM3_CMPRSS_ZEROIZE_EN
      check("soft clr A..H zero", dut.st, '0);
      check("soft clr hash_o zero", hash_o, '0);
`else
      check("soft clr V kept (IV)", hash_o, IV_WORDS);
`endif
      start_blk(1'b1);
      feed(64, 1'b0, 1'b0, stalls);
      wait_hash();
      check("abc after soft clear", hash_o, ABC_DIGEST);
      accept();
      check("final idle busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sm3_cmprss_ctrl.md
Name: sm3_cmprss_ctrl

Overview:
- Iterative SM3 compression controller for one 512-bit block per job.
- Holds working registers A..H and chaining value V. Sequences the combinational single-round ceil sm3_cmprss_ceil_comb for 64 rounds, one round per clock.
- Per round, generates the pre-rotated Tj and the round<16 select. Consumes one (Wj, W'j) pair per round from the message-expansion stage.
- Produces V(i+1) = ABCDEFGH ^ V(i) on a valid/ready output port.

Parameters:
- ROUNDS, 64, number of compression rounds; fixed to 64 for SM3; other values are simulation-only.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- blk_start_i  in  1  start a block; sampled only in IDLE
- blk_first_i  in  1  sampled with blk_start_i; 1 = chain from IV, 0 = chain from current V
- soft_clr_i  in  1  synchronous abort; returns to IDLE
- wj_valid_i  in  1  Wj/W'j pair valid
- wj_i  in  32  Wj
- wjj_i  in  32  W'j
- wj_ready_o  out  1  round consumes the pair this cycle
- busy_o  out  1  state != IDLE
- round_o  out  6  current round index j
- hash_valid_o  out  1  hash_o valid
- hash_ready_i  in  1  downstream accepts hash
- hash_o  out  256  V register, {A,B,...,H} with A in [255:224]

Behaviour:
- Reset: state=IDLE. A..H=0, V=0, round=0. All outputs 0, hash_o=0.
- States: IDLE, RUN, FINAL, DONE.
- IDLE, blk_start_i=1 → RUN.
  - A..H <= (blk_first_i ? IV : V). V <= same source. round <= 0.
  - IV = 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e.
- RUN:
  - wj_ready_o=1.
  - On wj_valid_i: A..H <= ceil outputs; round++.
  - No valid: registers hold; stalls are unbounded.
  - Handshake on round=63 → FINAL.
- FINAL (1 cycle): V <= {A..H} ^ V → DONE.
- DONE: hash_valid_o=1 and hash_o stable until hash_ready_i; then → IDLE.
  - V is retained after the handshake for chaining.
- Ceil drive:
  - cmprss_round_sm_16_i = (round<16).
  - tj_i = T <<< (round mod 32), with T=79cc4519 for j<16, else 7a879d8a. The ceil does not rotate Tj itself.
  - Tj may come from a rotating register loaded at start and at j=16; the result must equal the formula.
- Latency: start accepted at edge 0, continuous valid → 64 rounds at edges 1..64, FINAL cycle 65, hash_valid_o high from cycle 66.
- All arithmetic is mod 2^32 inside the ceil. The round counter never wraps inside RUN.
- wj_ready_o=0 outside RUN. blk_start_i outside IDLE is ignored.
- soft_clr_i has priority over all transitions:
  - → IDLE, round=0, hash_valid_o=0.
  - A..H are left unchanged and V is left unchanged. Next block must use blk_first_i=1 or re-chain knowingly.
- A hash_ready_i and blk_start_i in the same DONE cycle: start is ignored; it must be reissued in IDLE.

Optional Feature:
- SM3_CMPRSS_ZEROIZE_EN defined:
  - In FINAL, A..H <= 0.
  - On soft_clr_i, A..H <= 0 and V <= 0.
  - hash_o is forced to 0 whenever hash_valid_o=0.
- Undefined: working registers retain values; hash_o always shows V.

Decomposition:
- sm3_cfg.v holds:
  - IV words SM3_IV_A..H.
  - Tj constants SM3_T_LO=79cc4519, SM3_T_HI=7a879d8a.
  - State encodings.
  - SM3_CMPRSS_ZEROIZE_EN.
- Instantiates the existing sm3_cmprss_ceil_comb. SM3_CMPRSS_DIRECT_ADD remains orthogonal.
- One natural sub-module: sm3_tj_gen, a round-indexed pre-rotated Tj generator (register + rotate-by-1).

Test Plan:
- Reset mid-RUN (rst_n low at round 20) → busy_o=0, hash_valid_o=0, hash_o=0 immediately, asynchronous. Next block starts cleanly.
- Tj check: probe tj_i → j=0 79cc4519, j=1 f3988a32, j=16 9d8a7a87, j=33 f50f3b14. cmprss_round_sm_16_i falls at j=16.
- Single block "abc" (padded), blk_first_i=1, continuous W from the model:
  - hash_valid_o at cycle 66.
  - hash_o = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
- Random wj_valid_i gaps (50% duty) on the same message → identical hash; round_o advances only on handshake; latency = 2 + 64 + stall cycles.
- Two-block 64×"abcd" message (second block blk_first_i=0) → hash_o = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732. hash_ready_i held low 10 cycles → hash_o stable.
- soft_clr_i at round 40, then new "abc" block with blk_first_i=1 → correct "abc" digest. With ZEROIZE_EN, A..H read 0 after the clear.
